// File: rtl/cls_sub_16bit_seq.sv
// Iterative carry-select subtractor: diff = a + ~b + 1, one SLICE-bit slice per clock, LSB first.
// Optional zero/overflow flag outputs are enabled by defining CLS_SUB_FLAGS_EN.
module cls_sub_16bit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             carry_out
`ifdef CLS_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef CLS_SUB_FLAGS_EN
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
`endif

  int               idx;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] nb_sl;
  logic [SLICE:0]   sum0;
  logic [SLICE:0]   sum1;
  logic [SLICE:0]   sel;

  // Both slice candidates are formed up front; the registered carry picks one.
  always_comb begin
    idx   = int'(cnt_q) * SLICE;
    a_sl  = a_q[idx +: SLICE];
    nb_sl = nb_q[idx +: SLICE];
    sum0  = {1'b0, a_sl} + {1'b0, nb_sl};
    sum1  = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE{1'b0}}, 1'b1};
    sel   = carry_q ? sum1 : sum0;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    nb_d        = nb_q;
    diff_d      = diff_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
`ifdef CLS_SUB_FLAGS_EN
    zero_d      = zero_q;
    overflow_d  = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        diff_d[idx +: SLICE] = sel[SLICE-1:0];
        carry_d              = sel[SLICE];
        cnt_d                = cnt_q + 1'b1;
        if (cnt_q == CW'(NS - 1)) begin
          carry_out_d = sel[SLICE];
          state_d     = DONE;
`ifdef CLS_SUB_FLAGS_EN
          zero_d      = (diff_d == '0);
          // Operand signs differ exactly when a's MSB equals ~b's MSB.
          overflow_d  = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sel[SLICE-1] != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      diff_q      <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
`ifdef CLS_SUB_FLAGS_EN
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      diff_q      <= diff_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
`ifdef CLS_SUB_FLAGS_EN
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign carry_out = carry_out_q;
`ifdef CLS_SUB_FLAGS_EN
  assign zero      = zero_q;
  assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_cls_sub_16bit_seq.sv
// Scoreboard bench for cls_sub_16bit_seq: the driver queues expected results at accept time,
// and a negedge monitor compares them whenever the DUT presents out_valid.
module tb_cls_sub_16bit_seq;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int NS    = WIDTH / SLICE;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        carry_out;
`ifdef CLS_SUB_FLAGS_EN
  logic        zero;
  logic        overflow;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   checks       = 0;
  int   errors       = 0;
  int   cycle        = 0;
  int   accept_cycle = 0;
  logic prev_ov      = 1'b0;
  logic sweep_done   = 1'b0;

  cls_sub_16bit_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .carry_out (carry_out)
`ifdef CLS_SUB_FLAGS_EN
    ,
    .zero      (zero),
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference result straight from unsigned arithmetic on the operands.
  function automatic exp_t refModel(input logic [15:0] ta, input logic [15:0] tb_v);
    exp_t e;
    e.d = ta - tb_v;
    e.c = (ta >= tb_v);
    e.z = (e.d == 16'h0000);
    e.o = (ta[15] != tb_v[15]) && (e.d[15] != ta[15]);
    return e;
  endfunction

  task applyStimulus(input logic [15:0] ta, input logic [15:0] tb_v);
    exp_t e;
    int   n;
    e        = refModel(ta, tb_v);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      accept_cycle = cycle;
      sb.push_back(e);
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
    end
  endtask

  task waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d_pending required=0_pending", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: busy/ready agreement, latency, and result comparison against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (sb.size() == 0)});
      if (out_valid && !prev_ov)
        checkOutput("latency", cycle - accept_cycle, NS);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual=out_valid_high required=no_result diff=0x%0h", diff);
        end else begin
          checkOutput("diff", {16'b0, diff}, {16'b0, sb[0].d});
          checkOutput("carry_out", {31'b0, carry_out}, {31'b0, sb[0].c});
`ifdef CLS_SUB_FLAGS_EN
          checkOutput("zero", {31'b0, zero}, {31'b0, sb[0].z});
          checkOutput("overflow", {31'b0, overflow}, {31'b0, sb[0].o});
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    logic [15:0] corners [4];
    logic [15:0] ta;
    logic [15:0] tb_v;
    corners[0] = 16'h0000;
    corners[1] = 16'h7FFF;
    corners[2] = 16'h8000;
    corners[3] = 16'hFFFF;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_diff", {16'b0, diff}, 32'h0);
    checkOutput("rst_carry", {31'b0, carry_out}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] directed operands");
    out_ready = 1'b1;
    applyStimulus(16'h0005, 16'h0003); waitDrain();
    applyStimulus(16'h0000, 16'h0001); waitDrain();
    applyStimulus(16'h8000, 16'h0001); waitDrain();
    applyStimulus(16'h1234, 16'h1234); waitDrain();
    applyStimulus(16'h0000, 16'h0000); waitDrain();

    $display("[TB] backpressure with a stray in_valid");
    out_ready = 1'b0;
    applyStimulus(16'hF0F0, 16'h0F0F);
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h2222;
    repeat (NS + 10) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_diff", {16'b0, diff}, 32'h0000E1E1);
    checkOutput("bp_carry", {31'b0, carry_out}, 32'd1);
    checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset during calculation");
    applyStimulus(16'h00FF, 16'h0001);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_diff", {16'b0, diff}, 32'h0);
    checkOutput("midrst_carry", {31'b0, carry_out}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (NS + 4) @(posedge clk);
    #1;

    $display("[TB] random sweep with stalls");
    fork
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          ta   = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
          tb_v = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
          applyStimulus(ta, tb_v);
        end
        waitDrain();
        sweep_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
